alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Issuing side of the ALU opcode/operand interface. Accepts packed instruction words from a
//  host over valid/ready, decodes them and drives opcode/data1/data2 into the combinational ALU.
//  Waits a fixed settle time, captures the 8-bit result and returns it with zero/error flags.
//  Holds an accumulator so that instructions can chain on the previous result.
// PARAMETERS
//  SETTLE_CYCLES  1   cycles the ALU inputs are held before result capture (legal range 1..15)
//  INSTR_W        21  instruction width {use_acc[20], opcode[19:16], a[15:8], b[7:0]}; fixed
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high
//  in_valid   in   1   host instruction valid
//  in_ready   out  1   sequencer can accept an instruction
//  in_instr   in   21  packed instruction
//  alu_opcode out  4   to ALU opcode
//  alu_data1  out  8   to ALU data1
//  alu_data2  out  8   to ALU data2
//  alu_hasil  in   8   from ALU result
//  out_valid  out  1   response valid
//  out_ready  in   1   host accepts response
//  out_result out  8   captured result
//  out_zero   out  1   out_result == 0 (always 0 on an error response)
//  out_err    out  1   opcode 9..15 was rejected
// BEHAVIOUR
//  Opcodes: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SHR, 7 SHL, 8 NOT; 9..15 are invalid.
//  Reset (async): state IDLE, acc=0, alu_opcode=0, alu_data1=0, alu_data2=0, out_valid=0,
//   out_result=0, out_zero=0, out_err=0, in_ready=1 on the first cycle after deassertion.
//  FSM IDLE/ISSUE/RESP, all outputs registered except in_ready = (state==IDLE).
//  IDLE: on in_valid&in_ready, latch the instruction. d1 = use_acc ? acc : a; d2 = b.
//   - opcode 1..8: go to ISSUE, load cnt=SETTLE_CYCLES-1, drive alu_opcode/data1/data2.
//   - opcode 0: go to RESP with out_result=0, out_zero=1, out_err=0; ALU is not driven; acc kept.
//   - opcode 9..15: go to RESP with out_result=0, out_zero=0, out_err=1; acc kept.
//  ISSUE: ALU inputs stay stable. When cnt==0, capture alu_hasil into out_result and acc,
//   set out_zero=(alu_hasil==0) and out_err=0, clear alu_opcode/data1/data2 to 0, go to RESP.
//   Otherwise decrement cnt.
//  Latency from the accepting edge to out_valid high: SETTLE_CYCLES+1 edges for an ALU op;
//   1 edge for NOP or error.
//  RESP: out_valid=1. out_result and flags hold stable until out_valid&out_ready. On that edge,
//   out_valid goes to 0 and the state returns to IDLE. in_ready is 0 throughout, so at most one
//   instruction is in flight and there is no accept/response overlap.
//  Width rules: ADD/SUB wrap mod 256 inside the ALU. The sequencer adds no carry and no widening.
//  Reset mid-operation (ISSUE or RESP): the pending response is discarded, acc returns to 0 and no
//   out_valid pulse appears.
//  in_instr is sampled only on the accepting edge. Changes at any other time are ignored.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_NOP..OP_NOT), OP_MAX_VALID=8, instruction field offsets and
//   INSTR_W, and FSM state encodings.
//  Sub-module alu_op_decode (combinational): opcode -> {is_nop, is_valid}. Everything else lives
//   in alu_sequencer.
//  The bench pairs alu_sequencer with the existing ALU as the DUT pair.
// TESTING
//  1 ADD: {0,4,0x7F,0x01}, out_ready=1 -> out_result=0x80, zero=0, err=0; out_valid 2 edges
//    after accept (SETTLE_CYCLES=1).
//  2 SUB to zero: {0,5,0x05,0x05} -> out_result=0x00, zero=1, acc=0x00.
//  3 Chaining: {0,4,0x10,0x20} -> 0x30, then {1,7,0xEE,0x00} -> 0x60 (acc used for data1,
//    a ignored), then {1,8,0,0} -> 0x9F.
//  4 Invalid opcode: acc=0x30, send {0,0xA,0x12,0x34} -> err=1, result=0x00, out_valid 1 edge
//    after accept, acc stays 0x30, alu_opcode stays 0.
//  5 Backpressure: ADD 3+4 with out_ready low for 5 cycles -> out_result=0x07 held stable,
//    in_ready=0, extra in_valid ignored; one response only after out_ready rises.
//  6 Reset in ISSUE (SETTLE_CYCLES=4, reset 2 cycles after accept) -> no out_valid, all outputs
//    0, acc=0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issuing sequencer: opcode values, the
//   packed instruction layout, and the sequencer FSM state encoding.
//
//   Instruction word (INSTR_W = 21 bits):
//     [20]    use_acc  take data1 from the accumulator instead of field a
//     [19:16] opcode   0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB,
//                      6 SHR, 7 SHL, 8 NOT; 9..15 are rejected
//     [15:8]  a        operand A (data1 when use_acc = 0)
//     [7:0]   b        operand B (always data2)
// -----------------------------------------------------------------------------
package alu_pkg;

  // Datapath and field geometry
  localparam int DATA_W      = 8;
  localparam int OPCODE_W    = 4;
  localparam int INSTR_W     = 21;
  localparam int USE_ACC_BIT = 20;
  localparam int OPCODE_LSB  = 16;
  localparam int A_LSB       = 8;
  localparam int B_LSB       = 0;

  // Opcodes understood by the ALU
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SHL = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'd8;

  // Highest opcode the ALU implements; anything above is an error response
  localparam logic [OPCODE_W-1:0] OP_MAX_VALID = OP_NOT;

  // Packed view of the instruction word; field order matches the bit layout
  typedef struct packed {
    logic                use_acc;
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } instr_t;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a host instruction
    ST_ISSUE = 2'd1,  // ALU inputs held while the result settles
    ST_RESP  = 2'd2   // response presented until the host takes it
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
//   Combinational opcode classifier for the sequencer.
//
//   Ports:
//     opcode_i    in  4  opcode field of the incoming instruction
//     is_nop_o    out 1  opcode is NOP (answered without driving the ALU)
//     is_valid_o  out 1  opcode is 0..OP_MAX_VALID (NOP counts as valid)
// -----------------------------------------------------------------------------
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                is_nop_o,
  output logic                is_valid_o
);

  always_comb begin
    // NOTE: every output gets a default first so always_comb cannot infer a latch.
    is_nop_o   = 1'b0;
    is_valid_o = 1'b0;
    if (opcode_i == OP_NOP) begin
      is_nop_o = 1'b1;
    end
    if (opcode_i <= OP_MAX_VALID) begin
      is_valid_o = 1'b1;
    end
  end

endmodule : alu_op_decode

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Issuing side of the ALU opcode/operand interface. Accepts one packed
//   instruction at a time over valid/ready, drives the combinational ALU,
//   holds its inputs for SETTLE_CYCLES, captures the result and returns it
//   with zero/error flags. An 8-bit accumulator keeps the last ALU result so
//   an instruction can use it as data1 (use_acc).
//
//   Parameters:
//     SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//
//   Ports:
//     clk         in   1   clock, rising edge
//     reset       in   1   asynchronous, active-high
//     in_valid    in   1   host instruction valid
//     in_ready    out  1   sequencer idle and able to accept
//     in_instr    in   21  packed instruction (see alu_pkg)
//     alu_opcode  out  4   ALU opcode, 0 whenever the ALU is not in use
//     alu_data1   out  8   ALU operand 1
//     alu_data2   out  8   ALU operand 2
//     alu_hasil   in   8   ALU result
//     out_valid   out  1   response valid
//     out_ready   in   1   host accepts response
//     out_result  out  8   captured result (0 for NOP and error responses)
//     out_zero    out  1   out_result == 0 (never set on an error response)
//     out_err     out  1   instruction carried an opcode above OP_MAX_VALID
//
//   Latency from the accepting edge to out_valid: SETTLE_CYCLES+1 edges for
//   an ALU opcode, 1 edge for NOP or an invalid opcode. Only one instruction
//   is in flight; in_ready stays low until the response is taken.
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [DATA_W-1:0]   alu_data1,
  output logic [DATA_W-1:0]   alu_data2,
  input  logic [DATA_W-1:0]   alu_hasil,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_zero,
  output logic                out_err
);

  // Counter preload: cnt reaches 0 after SETTLE_CYCLES-1 decrements, so the
  // capture edge is SETTLE_CYCLES edges after the inputs were first driven.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_W-1:0]     acc_q;
  logic [OPCODE_W-1:0]   alu_opcode_q;
  logic [DATA_W-1:0]     alu_data1_q;
  logic [DATA_W-1:0]     alu_data2_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_result_q;
  logic                  out_zero_q;
  logic                  out_err_q;

  // ---------------------------------------------------------------------------
  // Instruction decode (only meaningful on the accepting edge)
  // ---------------------------------------------------------------------------
  instr_t            instr;
  logic              is_nop;
  logic              is_valid;
  logic              accept;
  logic [DATA_W-1:0] alu_data1_d;

  assign instr       = instr_t'(in_instr);
  assign alu_data1_d = instr.use_acc ? acc_q : instr.a;
  assign accept      = in_valid && (state_q == ST_IDLE);

  alu_op_decode u_op_decode (
    .opcode_i   (instr.opcode),
    .is_nop_o   (is_nop),
    .is_valid_o (is_valid)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Reset discards any pending work, including a half-finished ALU op.
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_opcode_q <= OP_NOP;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_valid && !is_nop) begin
              // Real ALU work: present operands and start the settle count.
              state_q      <= ST_ISSUE;
              cnt_q        <= CNT_INIT;
              alu_opcode_q <= instr.opcode;
              alu_data1_q  <= alu_data1_d;
              alu_data2_q  <= instr.b;
            end else begin
              // NOP and rejected opcodes answer immediately; the ALU stays
              // idle and the accumulator is untouched.
              state_q      <= ST_RESP;
              out_valid_q  <= 1'b1;
              out_result_q <= '0;
              out_zero_q   <= is_nop;
              out_err_q    <= !is_valid;
            end
          end
        end

        ST_ISSUE: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            out_valid_q  <= 1'b1;
            out_result_q <= alu_hasil;
            out_zero_q   <= (alu_hasil == '0);
            out_err_q    <= 1'b0;
            acc_q        <= alu_hasil;
            // Park the ALU interface at zero between operations.
            alu_opcode_q <= OP_NOP;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_RESP: begin
          // Result and flags hold until the host takes them.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == ST_IDLE);
  assign alu_opcode = alu_opcode_q;
  assign alu_data1  = alu_data1_q;
  assign alu_data2  = alu_data2_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer paired with a behavioural model of the ALU.
//   u_dut uses SETTLE_CYCLES=1 and runs the vector table, the invalid-opcode
//   and backpressure sequences; u_dut4 uses SETTLE_CYCLES=4 for the longer
//   latency and the reset-during-ISSUE sequence.
//   Inputs change 1 time unit after a rising edge; outputs are read either
//   1 unit after a rising edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock, counters
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU behaviour: shifts move data1 by one bit, NOT inverts data1,
  // ADD/SUB wrap modulo 256.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] d1,
                                           input logic [7:0] d2);
    case (op)
      4'd1:    return d1 & d2;
      4'd2:    return d1 | d2;
      4'd3:    return d1 ^ d2;
      4'd4:    return d1 + d2;
      4'd5:    return d1 - d2;
      4'd6:    return d1 >> 1;
      4'd7:    return d1 << 1;
      4'd8:    return ~d1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [20:0] mk(input logic use_acc, input logic [3:0] op,
                                     input logic [7:0] a, input logic [7:0] b);
    return {use_acc, op, a, b};
  endfunction

  // ---------------------------------------------------------------------------
  // DUT 1: SETTLE_CYCLES = 1
  // ---------------------------------------------------------------------------
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [20:0] in_instr;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_data1, alu_data2, alu_hasil, out_result;

  alu_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_hasil  (alu_hasil),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  always_comb alu_hasil = alu_model(alu_opcode, alu_data1, alu_data2);

  // ---------------------------------------------------------------------------
  // DUT 2: SETTLE_CYCLES = 4
  // ---------------------------------------------------------------------------
  logic        reset4, in_valid4, in_ready4, out_valid4, out_ready4, out_zero4, out_err4;
  logic [20:0] in_instr4;
  logic [3:0]  alu_opcode4;
  logic [7:0]  alu_data14, alu_data24, alu_hasil4, out_result4;

  alu_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset4),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .in_instr   (in_instr4),
    .alu_opcode (alu_opcode4),
    .alu_data1  (alu_data14),
    .alu_data2  (alu_data24),
    .alu_hasil  (alu_hasil4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .out_result (out_result4),
    .out_zero   (out_zero4),
    .out_err    (out_err4)
  );

  always_comb alu_hasil4 = alu_model(alu_opcode4, alu_data14, alu_data24);

  // ---------------------------------------------------------------------------
  // Scoreboard for u_dut: expected responses queued at issue, popped when
  // the host-side handshake is seen on the falling edge before it completes.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] result;
    logic       zero;
    logic       err;
  } resp_t;

  resp_t sb_q[$];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("response expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        resp_t e;
        e = sb_q.pop_front();
        check("out_result", 32'(out_result), 32'(e.result));
        check("out_zero",   32'(out_zero),   32'(e.zero));
        check("out_err",    32'(out_err),    32'(e.err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [20:0] instr;
    logic [7:0]  result;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  // Issue one instruction on u_dut, check the ALU drive and latency, then
  // wait for the scoreboard to see the response.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int guard;
    @(posedge clk); #1;
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = v.instr;
    sb_q.push_back('{v.result, v.zero, v.err});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = '1;  // garbage after the accepting edge must be ignored
    lat = 1;
    if (v.lat > 1) begin
      check($sformatf("v%0d alu_opcode driven", idx), 32'(alu_opcode), 32'(v.instr[19:16]));
    end else begin
      check($sformatf("v%0d alu_opcode idle", idx), 32'(alu_opcode), 32'd0);
    end
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d alu parked", idx), 32'(alu_opcode), 32'd0);
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d response seen", idx), 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Issue one instruction on u_dut4 (out_ready4 held high) and check it directly.
  task automatic run4(input string name, input logic [20:0] instr, input logic [7:0] exp_res,
                      input logic exp_zero, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    check({name, " in_ready"}, 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1;
    in_instr4 = instr;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"},  32'(out_result4), 32'(exp_res));
    check({name, " zero"},    32'(out_zero4), 32'(exp_zero));
    check({name, " err"},     32'(out_err4), 32'd0);
    @(posedge clk); #1;
    check({name, " valid dropped"}, 32'(out_valid4), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int seen;

    //          instr                         result zero err lat
    vecs[0]  = '{mk(1'b0, 4'h4, 8'h7F, 8'h01), 8'h80, 1'b0, 1'b0, 2}; // ADD
    vecs[1]  = '{mk(1'b0, 4'h5, 8'h05, 8'h05), 8'h00, 1'b1, 1'b0, 2}; // SUB to zero
    vecs[2]  = '{mk(1'b0, 4'h4, 8'h10, 8'h20), 8'h30, 1'b0, 1'b0, 2}; // chain start
    vecs[3]  = '{mk(1'b1, 4'h7, 8'hEE, 8'h00), 8'h60, 1'b0, 1'b0, 2}; // SHL acc
    vecs[4]  = '{mk(1'b1, 4'h8, 8'h00, 8'h00), 8'h9F, 1'b0, 1'b0, 2}; // NOT acc
    vecs[5]  = '{mk(1'b0, 4'h4, 8'h30, 8'h00), 8'h30, 1'b0, 1'b0, 2}; // acc = 0x30
    vecs[6]  = '{mk(1'b0, 4'hA, 8'h12, 8'h34), 8'h00, 1'b0, 1'b1, 1}; // invalid
    vecs[7]  = '{mk(1'b1, 4'h4, 8'h00, 8'h00), 8'h30, 1'b0, 1'b0, 2}; // acc kept
    vecs[8]  = '{mk(1'b0, 4'h0, 8'hFF, 8'hFF), 8'h00, 1'b1, 1'b0, 1}; // NOP
    vecs[9]  = '{mk(1'b1, 4'h1, 8'h00, 8'hF0), 8'h30, 1'b0, 1'b0, 2}; // AND acc (NOP kept acc)
    vecs[10] = '{mk(1'b0, 4'h2, 8'hA0, 8'h05), 8'hA5, 1'b0, 1'b0, 2}; // OR
    vecs[11] = '{mk(1'b0, 4'h3, 8'hFF, 8'h0F), 8'hF0, 1'b0, 1'b0, 2}; // XOR
    vecs[12] = '{mk(1'b0, 4'h6, 8'h81, 8'h00), 8'h40, 1'b0, 1'b0, 2}; // SHR
    vecs[13] = '{mk(1'b0, 4'h5, 8'h00, 8'h01), 8'hFF, 1'b0, 1'b0, 2}; // SUB wraps
    vecs[14] = '{mk(1'b0, 4'h4, 8'hFF, 8'h01), 8'h00, 1'b1, 1'b0, 2}; // ADD wraps
    vecs[15] = '{mk(1'b1, 4'hF, 8'h55, 8'h66), 8'h00, 1'b0, 1'b1, 1}; // invalid 15
    vecs[16] = '{mk(1'b1, 4'h4, 8'h00, 8'h00), 8'h00, 1'b1, 1'b0, 2}; // acc still 0

    reset      = 1'b1;
    reset4     = 1'b1;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    in_instr   = '0;
    in_instr4  = '0;
    out_ready  = 1'b1;
    out_ready4 = 1'b1;

    #1;
    check("rst out_valid",  32'(out_valid),  32'd0);
    check("rst out_result", 32'(out_result), 32'd0);
    check("rst out_zero",   32'(out_zero),   32'd0);
    check("rst out_err",    32'(out_err),    32'd0);
    check("rst alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst alu_data1",  32'(alu_data1),  32'd0);
    check("rst alu_data2",  32'(alu_data2),  32'd0);

    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    reset4 = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready",  32'(in_ready),  32'd1);
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: ADD 3+4 with the host stalled for 5 cycles while it
    // keeps offering another instruction.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_instr = mk(1'b0, 4'h4, 8'h03, 8'h04);
    sb_q.push_back('{8'h07, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp out_valid rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = mk(1'b0, 4'h4, 8'h50, 8'h50);
      @(negedge clk);
      check($sformatf("bp%0d out_valid", i),  32'(out_valid),  32'd1);
      check($sformatf("bp%0d out_result", i), 32'(out_result), 32'h07);
      check($sformatf("bp%0d in_ready", i),   32'(in_ready),   32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp handshake drop", 32'(out_valid), 32'd0);
    check("bp in_ready back",  32'(in_ready),  32'd1);
    check("bp scoreboard",     32'(sb_q.size()), 32'd0);
    sb_q.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp single response", 32'(seen), 32'd0);

    // SETTLE_CYCLES = 4: normal latency, then reset two cycles into ISSUE.
    run4("s4 add", mk(1'b0, 4'h4, 8'h22, 8'h11), 8'h33, 1'b0, 5);

    @(posedge clk); #1;
    in_valid4 = 1'b1;
    in_instr4 = mk(1'b0, 4'h4, 8'h01, 8'h02);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("s4 issue opcode", 32'(alu_opcode4), 32'd4);
    @(posedge clk); @(posedge clk); #1;
    reset4 = 1'b1;
    #1;
    check("s4 rst out_valid",  32'(out_valid4),  32'd0);
    check("s4 rst out_result", 32'(out_result4), 32'd0);
    check("s4 rst alu_opcode", 32'(alu_opcode4), 32'd0);
    check("s4 rst alu_data1",  32'(alu_data14),  32'd0);
    check("s4 rst alu_data2",  32'(alu_data24),  32'd0);
    check("s4 rst flags",      32'({out_zero4, out_err4}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid4) seen++;
    end
    check("s4 no stale response", 32'(seen), 32'd0);
    check("s4 in_ready after rst", 32'(in_ready4), 32'd1);
    // Accumulator must be 0 again: acc + 5 = 5 (0x38 if it survived reset).
    run4("s4 acc cleared", mk(1'b1, 4'h4, 8'h77, 8'h05), 8'h05, 1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_sequencer
